// File: rtl/psa_sub_seq_pkg.sv
// Shared ALU definitions for the sequential PSA subtractor.
// Holds FSM encodings, lane width and saturation constants.
package psa_sub_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] SAT_POS = 4'h7;
  localparam logic [NIBBLE_W-1:0] SAT_NEG = 4'h8;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CALC = 3'b010,
    DONE = 3'b100
  } state_t;

endpackage

// File: rtl/psa_nibble_sub.sv
// One signed 4-bit lane of the PSA subtractor.
// Combinational difference with overflow detect and optional clamp.
module psa_nibble_sub
  import psa_sub_seq_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [NIBBLE_W-1:0] res,
  output logic                ovf
);

  logic [NIBBLE_W:0] d;

  // d[4] is the true sign; a mismatch with d[3] means out of range
  always_comb begin
    d   = {a[NIBBLE_W-1], a} - {b[NIBBLE_W-1], b};
    ovf = d[NIBBLE_W] ^ d[NIBBLE_W-1];
    res = d[NIBBLE_W-1:0];
    if (ovf && SATURATE) begin
      res = d[NIBBLE_W] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/psa_sub_seq.sv
// Multi-cycle parallel sub-word subtractor, one lane per cycle.
// Valid/ready on both sides; result held in DONE until taken.
module psa_sub_seq
  import psa_sub_seq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NIBBLES  = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             ovfl
);

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [CNT_W-1:0]    cnt;
  logic [NIBBLE_W-1:0] a_ln;
  logic [NIBBLE_W-1:0] b_ln;
  logic [NIBBLE_W-1:0] res_ln;
  logic                ovf_ln;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): if (in_valid) state_nx = CALC;
      (state == CALC): if (cnt == LAST) state_nx = DONE;
      (state == DONE): if (out_ready) state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_ln = '0;
    b_ln = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_ln = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_ln = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  psa_nibble_sub #(
    .SATURATE (SATURATE)
  ) u_lane (
    .a   (a_ln),
    .b   (b_ln),
    .res (res_ln),
    .ovf (ovf_ln)
  );

  // Operands are captured once so later A/B changes cannot leak in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      Diff <= '0;
      ovfl <= 1'b0;
      cnt  <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (in_valid) begin
            a_q  <= A;
            b_q  <= B;
            Diff <= '0;
            ovfl <= 1'b0;
            cnt  <= '0;
          end
        end
        (state == CALC): begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CNT_W'(i)) begin
              Diff[i*NIBBLE_W +: NIBBLE_W] <= res_ln;
            end
          end
          ovfl <= ovfl | ovf_ln;
          cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psa_sub_seq.sv
// Bench for psa_sub_seq: directed cases, backpressure, reset abort
// and random pairs against a per-lane arithmetic model.
module tb_psa_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic        in_ready_s, out_valid_s, ovfl_s;
  logic [15:0] diff_s;
  logic        in_ready_w, out_valid_w, ovfl_w;
  logic [15:0] diff_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psa_sub_seq #(.WIDTH(16), .NIBBLES(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .out_valid(out_valid_s), .out_ready(out_ready),
    .Diff(diff_s), .ovfl(ovfl_s)
  );

  psa_sub_seq #(.WIDTH(16), .NIBBLES(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .out_valid(out_valid_w), .out_ready(out_ready),
    .Diff(diff_w), .ovfl(ovfl_w)
  );

  // Returns {ovf, diff}; lanes are plain signed integers in -8..7
  function automatic logic [16:0] ref_op(logic [15:0] a, logic [15:0] b,
                                         bit sat);
    logic [15:0] d;
    logic        o;
    int          x, y, r;
    d = '0;
    o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = int'(a[i*4 +: 4]);
      y = int'(b[i*4 +: 4]);
      if (x > 7) x -= 16;
      if (y > 7) y -= 16;
      r = x - y;
      if (r > 7 || r < -8) begin
        o = 1'b1;
        if (sat) r = (r > 7) ? 7 : -8;
      end
      d[i*4 +: 4] = 4'(r);
    end
    return {o, d};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(logic [15:0] a, logic [15:0] b);
    int n;
    n = 0;
    while (!in_ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", {31'd0, in_ready_s}, 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  task automatic finish_op(logic [15:0] a, logic [15:0] b, int hold);
    int n;
    logic [16:0] rs, rw;
    rs = ref_op(a, b, 1'b1);
    rw = ref_op(a, b, 1'b0);
    n = 0;
    while (!out_valid_s && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 4);
    check("out_valid_wrap", {31'd0, out_valid_w}, 32'd1);
    check("diff_sat", {16'd0, diff_s}, {16'd0, rs[15:0]});
    check("ovfl_sat", {31'd0, ovfl_s}, {31'd0, rs[16]});
    check("diff_wrap", {16'd0, diff_w}, {16'd0, rw[15:0]});
    check("ovfl_wrap", {31'd0, ovfl_w}, {31'd0, rw[16]});
    check("in_ready_busy", {31'd0, in_ready_s}, 32'd0);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      A = 16'($urandom);
      B = 16'($urandom);
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid_s}, 32'd1);
      check("bp_ready", {31'd0, in_ready_s}, 32'd0);
      check("bp_diff", {15'd0, ovfl_s, diff_s}, {15'd0, rs});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("drop_valid", {31'd0, out_valid_s}, 32'd0);
    check("back_idle", {31'd0, in_ready_s}, 32'd1);
  endtask

  task automatic run_op(logic [15:0] a, logic [15:0] b);
    start_op(a, b);
    finish_op(a, b, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
    check("rst_diff", {16'd0, diff_s}, 32'd0);
    check("rst_ovfl", {31'd0, ovfl_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h0000, 16'h0000);
    run_op(16'h5A3C, 16'h2143);
    run_op(16'h7777, 16'hFFFF);
    run_op(16'h8888, 16'h1111);
    run_op(16'h8F00, 16'h1000);

    start_op(16'h1234, 16'h4321);
    finish_op(16'h1234, 16'h4321, 3);
    run_op(16'h7F80, 16'h8F7F);

    start_op(16'h1234, 16'h0101);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid_s}, 32'd0);
    check("abort_diff", {16'd0, diff_s}, 32'd0);
    check("abort_ovfl", {31'd0, ovfl_s}, 32'd0);
    check("abort_ready", {31'd0, in_ready_s}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h2D6E, 16'hB3A1);

    for (int k = 0; k < 200; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
